// File: rtl/rs_bank.sv
// Reservation-station bank for one functional-unit class.
// Accepts issued instructions into free entries, snoops the CDB for missing
// operands, dispatches ready entries one at a time to the functional unit and
// frees an entry when its own result tag is broadcast.
//
// Handshakes (valid/ready semantics):
//   issue:    in_issue_enable is the request, held by the issuer until it sees
//             out_issue_ack; the ack is a one-cycle registered pulse, and no
//             allocation happens while it is high, so a held request cannot be
//             accepted twice.
//   dispatch: in_fu_ready is the FU's ready; out_fu_enable is a one-cycle
//             registered valid with out_fu_* fields. A new dispatch is never
//             launched while out_fu_enable is high (one per two cycles).
module rs_bank #(
  parameter int         NUM_ENTRIES = 4,
  parameter logic [4:0] TAG_BASE    = 5'd0,
  parameter logic [4:0] INVALID_TAG = 5'b11111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_issue_enable,
  input  logic [4:0]  in_operator_type,
  input  logic [31:0] in_val_1,
  input  logic [31:0] in_val_2,
  input  logic [4:0]  in_tag_1,
  input  logic [4:0]  in_tag_2,
  output logic        out_issue_ack,
  output logic [4:0]  out_issue_tag,
  output logic        out_full,
  input  logic        in_CDB_broadcast,
  input  logic [4:0]  in_CDB_tag,
  input  logic [31:0] in_CDB_val,
  input  logic        in_fu_ready,
  output logic        out_fu_enable,
  output logic [4:0]  out_fu_operator_type,
  output logic [31:0] out_fu_val_1,
  output logic [31:0] out_fu_val_2,
  output logic [4:0]  out_fu_tag
);

  typedef enum logic [1:0] {
    E_FREE    = 2'd0,
    E_WAITING = 2'd1,
    E_READY   = 2'd2,
    E_EXEC    = 2'd3
  } entry_state_e;

  entry_state_e state_q [NUM_ENTRIES];
  entry_state_e state_d [NUM_ENTRIES];
  logic [4:0]   op_q    [NUM_ENTRIES];
  logic [4:0]   op_d    [NUM_ENTRIES];
  logic [4:0]   tag1_q  [NUM_ENTRIES];
  logic [4:0]   tag1_d  [NUM_ENTRIES];
  logic [4:0]   tag2_q  [NUM_ENTRIES];
  logic [4:0]   tag2_d  [NUM_ENTRIES];
  logic [31:0]  val1_q  [NUM_ENTRIES];
  logic [31:0]  val1_d  [NUM_ENTRIES];
  logic [31:0]  val2_q  [NUM_ENTRIES];
  logic [31:0]  val2_d  [NUM_ENTRIES];

  logic        issue_ack_q, issue_ack_d;
  logic [4:0]  issue_tag_q, issue_tag_d;
  logic        fu_enable_q, fu_enable_d;
  logic [4:0]  fu_op_q, fu_op_d;
  logic [31:0] fu_val1_q, fu_val1_d;
  logic [31:0] fu_val2_q, fu_val2_d;
  logic [4:0]  fu_tag_q, fu_tag_d;

  logic cdb_hit;   // broadcast carries a real (non-invalid) tag
  logic any_free;
  logic dsp_done;
  logic iss_done;

  function automatic logic [4:0] own_tag(input int idx);
    return TAG_BASE + 5'(idx);
  endfunction

  // Full flag comes from registered entry state only.
  always_comb begin
    any_free = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (state_q[i] == E_FREE) any_free = 1'b1;
    end
  end

  // Per-entry next state: snoop waiting entries, dispatch the lowest ready
  // entry, free completed entries, allocate the lowest free entry.
  always_comb begin
    cdb_hit     = in_CDB_broadcast && (in_CDB_tag != INVALID_TAG);
    issue_ack_d = 1'b0;
    issue_tag_d = issue_tag_q;
    fu_enable_d = 1'b0;
    fu_op_d     = fu_op_q;
    fu_val1_d   = fu_val1_q;
    fu_val2_d   = fu_val2_q;
    fu_tag_d    = fu_tag_q;
    dsp_done    = 1'b0;
    iss_done    = 1'b0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      state_d[i] = state_q[i];
      op_d[i]    = op_q[i];
      tag1_d[i]  = tag1_q[i];
      tag2_d[i]  = tag2_q[i];
      val1_d[i]  = val1_q[i];
      val2_d[i]  = val2_q[i];
    end
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      case (state_q[i])
        E_WAITING: begin
          if (cdb_hit && tag1_q[i] == in_CDB_tag) begin
            val1_d[i] = in_CDB_val;
            tag1_d[i] = INVALID_TAG;
          end
          if (cdb_hit && tag2_q[i] == in_CDB_tag) begin
            val2_d[i] = in_CDB_val;
            tag2_d[i] = INVALID_TAG;
          end
          if (tag1_d[i] == INVALID_TAG && tag2_d[i] == INVALID_TAG) state_d[i] = E_READY;
        end
        E_READY: begin
          if (!dsp_done && in_fu_ready && !fu_enable_q) begin
            dsp_done    = 1'b1;
            state_d[i]  = E_EXEC;
            fu_enable_d = 1'b1;
            fu_op_d     = op_q[i];
            fu_val1_d   = val1_q[i];
            fu_val2_d   = val2_q[i];
            fu_tag_d    = own_tag(i);
          end
        end
        E_EXEC: begin
          if (cdb_hit && in_CDB_tag == own_tag(i)) state_d[i] = E_FREE;
        end
        default: begin
          if (!iss_done && in_issue_enable && !issue_ack_q) begin
            iss_done    = 1'b1;
            issue_ack_d = 1'b1;
            issue_tag_d = own_tag(i);
            op_d[i]     = in_operator_type;
            // A tag broadcast on the allocating edge is taken directly.
            if (cdb_hit && in_tag_1 == in_CDB_tag) begin
              val1_d[i] = in_CDB_val;
              tag1_d[i] = INVALID_TAG;
            end else begin
              val1_d[i] = in_val_1;
              tag1_d[i] = in_tag_1;
            end
            if (cdb_hit && in_tag_2 == in_CDB_tag) begin
              val2_d[i] = in_CDB_val;
              tag2_d[i] = INVALID_TAG;
            end else begin
              val2_d[i] = in_val_2;
              tag2_d[i] = in_tag_2;
            end
            state_d[i] = (tag1_d[i] == INVALID_TAG && tag2_d[i] == INVALID_TAG) ? E_READY : E_WAITING;
          end
        end
      endcase
    end
  end

  // State and output registers; reset discards every entry.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= E_FREE;
        op_q[i]    <= '0;
        tag1_q[i]  <= INVALID_TAG;
        tag2_q[i]  <= INVALID_TAG;
        val1_q[i]  <= '0;
        val2_q[i]  <= '0;
      end
      issue_ack_q <= 1'b0;
      issue_tag_q <= '0;
      fu_enable_q <= 1'b0;
      fu_op_q     <= '0;
      fu_val1_q   <= '0;
      fu_val2_q   <= '0;
      fu_tag_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= state_d[i];
        op_q[i]    <= op_d[i];
        tag1_q[i]  <= tag1_d[i];
        tag2_q[i]  <= tag2_d[i];
        val1_q[i]  <= val1_d[i];
        val2_q[i]  <= val2_d[i];
      end
      issue_ack_q <= issue_ack_d;
      issue_tag_q <= issue_tag_d;
      fu_enable_q <= fu_enable_d;
      fu_op_q     <= fu_op_d;
      fu_val1_q   <= fu_val1_d;
      fu_val2_q   <= fu_val2_d;
      fu_tag_q    <= fu_tag_d;
    end
  end

  assign out_full             = ~any_free;
  assign out_issue_ack        = issue_ack_q;
  assign out_issue_tag        = issue_tag_q;
  assign out_fu_enable        = fu_enable_q;
  assign out_fu_operator_type = fu_op_q;
  assign out_fu_val_1         = fu_val1_q;
  assign out_fu_val_2         = fu_val2_q;
  assign out_fu_tag           = fu_tag_q;

endmodule

// File: doc/rs_bank.md
# rs_bank

Synchronous reservation-station bank for one functional-unit class in the Tomasulo core. It sits directly downstream of the current-instruction issue stage. It accepts an issued instruction (operator, two values, two source tags) into a free entry and returns that entry's tag for register-bank renaming. Entries snoop the CDB for missing operands, dispatch ready entries one at a time to the functional unit, and are freed when their own result tag appears on the CDB.

## Interface
- NUM_ENTRIES, 4, number of entries (1..8)
- TAG_BASE, 0, tag of entry 0; entry i owns tag TAG_BASE+i; TAG_BASE+NUM_ENTRIES-1 < INVALID_TAG
- INVALID_TAG, 5'b11111, source-tag value meaning "operand valid"

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst_n  in  1  reset, synchronous, active-low
- in_issue_enable  in  1  issue request; held high by issuer until ack
- in_operator_type  in  5  operator code
- in_val_1, in_val_2  in  32  operand values (meaningful when matching tag = INVALID_TAG)
- in_tag_1, in_tag_2  in  5  producing tags, INVALID_TAG if value valid
- out_issue_ack  out  1  one-cycle pulse: instruction accepted
- out_issue_tag  out  5  tag of accepted entry, valid with ack
- out_full  out  1  no FREE entry
- in_CDB_broadcast  in  1  CDB valid this cycle
- in_CDB_tag  in  5  broadcasting tag
- in_CDB_val  in  32  broadcast value
- in_fu_ready  in  1  functional unit can accept an operation
- out_fu_enable  out  1  one-cycle dispatch pulse
- out_fu_operator_type  out  5  dispatched operator
- out_fu_val_1, out_fu_val_2  out  32  dispatched operands
- out_fu_tag  out  5  result tag the FU must broadcast

## Operation
- Per-entry state: FREE, WAITING (≥1 tag ≠ INVALID_TAG), READY (both tags INVALID_TAG), EXECUTING.
- Issue: on an edge with in_issue_enable=1, out_issue_ack=0, and ≥1 FREE entry, allocate the lowest-index FREE entry. Capture operator, values, and tags. Go to READY if both tags are INVALID_TAG, else WAITING.
- Issue-time bypass: if in_CDB_broadcast=1 and in_tag_k == in_CDB_tag (tag ≠ INVALID_TAG) on the allocating edge, store in_CDB_val and INVALID_TAG for operand k.
- Snoop: every edge with in_CDB_broadcast=1, each WAITING entry whose tag_k == in_CDB_tag takes in_CDB_val and sets tag_k = INVALID_TAG. Both operands may match the same broadcast. The entry becomes READY when both tags are INVALID_TAG.
- Dispatch: on an edge with in_fu_ready=1 and out_fu_enable=0, select the lowest-index entry that is READY in registered state. Drive the out_fu_* fields, pulse out_fu_enable, and move the entry to EXECUTING. At most one dispatch per two cycles.
- Completion: an EXECUTING entry whose own tag == in_CDB_tag with in_CDB_broadcast=1 goes FREE. A broadcast of an unowned or INVALID_TAG tag frees nothing.
- out_full = no FREE entry, computed from registered state.
- Simultaneous issue, snoop, dispatch, and completion on one edge are all legal. They act on different entries, except that snoop and issue-bypass use the same broadcast.

## Timing
- Reset (rst_n=0 at edge): all entries FREE. out_issue_ack, out_fu_enable, and out_full = 0. out_issue_tag, out_fu_tag, out_fu_operator_type, and out_fu_val_* = 0. Reset mid-operation discards every entry, with no ack or dispatch on that edge.
- Issue latency: ack and tag are registered on the allocating edge and valid for exactly the following cycle. No allocation occurs while ack is high, so a held request is never accepted twice.
- Full: a request is stalled with no ack until an entry frees. An entry freed at edge N can be allocated at edge N+1.
- Snoop-to-ready: an operand captured at edge N can be dispatched at edge N+1 at the earliest.
- Dispatch latency: out_fu_* is valid for the single cycle after the dispatch edge.
- Minimum issue-to-dispatch is 1 edge for an instruction with both operands valid at issue.

## Test plan
- Reset, then issue ADD with tags (31,31), values 5 and 7, in_fu_ready=1 → ack with tag 0 next cycle; one cycle later out_fu_enable with vals 5/7 and tag 0. Broadcast tag 0 → entry 0 FREE.
- Issue with tag_1=3 and in_fu_ready=1 → no dispatch. Broadcast tag 3 with value 0xDEADBEEF → dispatch on the next edge with val_1=0xDEADBEEF.
- Issue with tag_1=tag_2=6 on the same edge as a CDB broadcast of tag 6 with value 9 → entry READY immediately; dispatches vals 9/9.
- Fill all 4 entries with unresolved tags → out_full=1 and the 5th request gets no ack. Resolve and complete entry 2 → the 5th request is acked with tag 2.
- Entries 1 and 3 READY with in_fu_ready=1 → entry 1 dispatched first, then entry 3 two cycles later. in_fu_ready=0 → no dispatch.
- Assert rst_n=0 mid-operation with entries EXECUTING → all outputs return to 0 and tag 0 is reallocated on the next issue.
